// File: rtl/apb_timer_pkg.sv
// Register map and field layout shared by the APB timer slave
// and anything that needs to decode its registers.
package apb_timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_RELOAD    = 1;
    localparam int CTRL_IRQ_EN    = 2;
    localparam int PRESCALE_LSB   = 8;
    localparam int PRESCALE_MSB   = 15;
    localparam int STATUS_EXPIRED = 0;

    typedef struct packed {
        logic [7:0] prescale;
        logic       irq_en;
        logic       reload;
        logic       en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_pack(input ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN]                    = c.en;
        w[CTRL_RELOAD]                = c.reload;
        w[CTRL_IRQ_EN]                = c.irq_en;
        w[PRESCALE_MSB:PRESCALE_LSB]  = c.prescale;
        return w;
    endfunction

endpackage

// File: rtl/apb_timer_if.sv
// APB bus bundle between the bridge (master) and the timer
// slave; Prdata is the only slave-driven signal.
interface apb_timer_if;

    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;

    modport master (
        output Pselx,
        output Penable,
        output Pwrite,
        output Paddr,
        output Pwdata,
        input  Prdata
    );

    modport slave (
        input  Pselx,
        input  Penable,
        input  Pwrite,
        input  Paddr,
        input  Pwdata,
        output Prdata
    );

endinterface

// File: rtl/apb_timer_prescaler.sv
// 8-bit prescaler: tick fires when pcnt reaches prescale,
// so prescale=P yields one tick every P+1 enabled cycles.
module apb_timer_prescaler (
    input  logic       Hclk,
    input  logic       Hreset,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] prescale,
    output logic       tick
);

    logic [7:0] pcnt;

    assign tick = en & (pcnt == prescale);

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            pcnt <= '0;
        end else if (!en || clr || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 8'd1;
        end
    end

endmodule

// File: rtl/apb_timer_slave.sv
// APB timer slave: register decode, 32-bit down-counter,
// sticky expiry flag, level irq and registered read data.
module apb_timer_slave
    import apb_timer_pkg::*;
#(
    parameter int SEL_IDX = 0
) (
    input  logic       Hclk,
    input  logic       Hreset,
    apb_timer_if.slave bus,
    output logic       irq
);

    logic        sel;
    logic        setup;
    logic        access;
    logic        wr;
    logic [1:0]  addr;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_status;
    logic        start;
    logic        tick;
    logic        expire;
    ctrl_t       ctrl;
    logic [31:0] load;
    logic [31:0] count;
    logic        expired;
    logic [31:0] rdata;
    logic [31:0] prdata;
    logic        unused_bits;

    assign sel       = bus.Pselx[SEL_IDX];
    assign setup     = sel & ~bus.Penable;
    assign access    = sel & bus.Penable;
    assign wr        = access & bus.Pwrite;
    assign addr      = bus.Paddr[3:2];
    assign wr_ctrl   = wr & (addr == REG_CTRL);
    assign wr_load   = wr & (addr == REG_LOAD);
    assign wr_status = wr & (addr == REG_STATUS);

    assign unused_bits = ^{bus.Paddr[31:4], bus.Paddr[1:0], bus.Pselx};

    // An enable edge restarts the prescale period from zero.
    assign start  = wr_ctrl & bus.Pwdata[CTRL_EN] & ~ctrl.en;
    assign expire = tick & (count == '0);

    apb_timer_prescaler u_prescaler (
        .Hclk     (Hclk),
        .Hreset   (Hreset),
        .en       (ctrl.en),
        .clr      (start),
        .prescale (ctrl.prescale),
        .tick     (tick)
    );

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            ctrl <= '0;
        end else if (wr_ctrl) begin
            ctrl.en       <= bus.Pwdata[CTRL_EN];
            ctrl.reload   <= bus.Pwdata[CTRL_RELOAD];
            ctrl.irq_en   <= bus.Pwdata[CTRL_IRQ_EN];
            ctrl.prescale <= bus.Pwdata[PRESCALE_MSB:PRESCALE_LSB];
        end else if (expire && !ctrl.reload) begin
            ctrl.en <= 1'b0;
        end
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            load <= '0;
        end else if (wr_load) begin
            load <= bus.Pwdata;
        end
    end

    // A LOAD write takes priority over any tick in the same cycle.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            count <= '0;
        end else if (wr_load) begin
            count <= bus.Pwdata;
        end else if (tick) begin
            if (count != '0) begin
                count <= count - 32'd1;
            end else if (ctrl.reload) begin
                count <= load;
            end
        end
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            expired <= 1'b0;
        end else if (expire) begin
            expired <= 1'b1;
        end else if (wr_status && bus.Pwdata[STATUS_EXPIRED]) begin
            expired <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (addr)
            REG_CTRL:   rdata = ctrl_pack(ctrl);
            REG_LOAD:   rdata = load;
            REG_COUNT:  rdata = count;
            REG_STATUS: rdata[STATUS_EXPIRED] = expired;
            default:    rdata = '0;
        endcase
    end

    // Captured on the read setup edge so it holds through access.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            prdata <= '0;
        end else if (!sel) begin
            prdata <= '0;
        end else if (setup && !bus.Pwrite) begin
            prdata <= rdata;
        end
    end

    assign bus.Prdata = prdata;
    assign irq        = expired & ctrl.irq_en;

endmodule
